// File: rtl/wait_change_monitor.sv
// Change detector for the wait-state thread output: timestamps each value
// change, queues {value, interval} records and flags cadence faults / drops.
module wait_change_monitor #(
  parameter int WIDTH           = 32,
  parameter int DEPTH           = 4,
  parameter int CNT_W           = 16,
  parameter int EXPECT_INTERVAL = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in1,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]        out_interval,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    interval_err,
  output logic                    overflow,
  output logic [CNT_W-1:0]        change_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_chg;
  logic                    r_ierr;
  logic                    r_ovf;

  logic [WIDTH-1:0] r_mem_d [DEPTH];
  logic [CNT_W-1:0] r_mem_i [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;

  logic w_event;
  logic w_first;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_int_bad;
  logic w_cnt_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_event = 1'b0;
    w_first = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next = S_ARMED;
      end
      S_ARMED: begin
        w_event = (in1 != r_prev);
        w_first = 1'b1;
        if (w_event) w_next = S_RUN;
      end
      S_RUN: begin
        w_event = (in1 != r_prev);
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

  assign w_pop     = out_valid & out_ready;
  assign w_push    = w_event & (~w_full | w_pop);
  assign w_drop    = w_event & w_full & ~w_pop;
  assign w_cnt_max = &r_cnt;
  assign w_int_bad = w_event & ~w_first &
                     (r_cnt != CNT_W'(EXPECT_INTERVAL));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= in1;
      if (r_state == S_IDLE || w_event) begin
        r_cnt <= CNT_W'(1);
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chg  <= '0;
      r_ierr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_event)   r_chg  <= r_chg + CNT_W'(1);
      if (w_int_bad) r_ierr <= 1'b1;
      if (w_drop)    r_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage needs no reset; empty pointers gate the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wr[AW-1:0]] <= in1;
      r_mem_i[r_wr[AW-1:0]] <= r_cnt;
    end
  end

  assign out_valid    = ~w_empty;
  assign out_data     = w_empty ? '0 : r_mem_d[r_rd[AW-1:0]];
  assign out_interval = w_empty ? '0 : r_mem_i[r_rd[AW-1:0]];
  assign interval_err = r_ierr;
  assign overflow     = r_ovf;
  assign change_cnt   = r_chg;

endmodule

// File: tb/tb_wait_change_monitor.sv
// Directed bench for wait_change_monitor: scoreboard of expected
// records, compared when the DUT hands a record to the consumer.
module tb_wait_change_monitor;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] in1 = '0;
  logic signed [31:0] out_data;
  logic [15:0]        out_interval;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               interval_err;
  logic               overflow;
  logic [15:0]        change_cnt;

  wait_change_monitor #(
    .WIDTH(32),
    .DEPTH(4),
    .CNT_W(16),
    .EXPECT_INTERVAL(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in1(in1),
    .out_data(out_data),
    .out_interval(out_interval),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .interval_err(interval_err),
    .overflow(overflow),
    .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [15:0] i;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ev = 0;
  bit   first = 1'b1;
  int   exp_cnt = 0;
  bit   exp_err = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // A record leaves the DUT at the next edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        rec_t r;
        r = q.pop_front();
        chk("out_data", 64'(out_data), 64'(r.v));
        chk("out_interval", 64'(out_interval), 64'(r.i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    q.delete();
    last_ev = cyc + 1;
    first = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
  endtask

  task automatic wait_gap(input int gap);
    while (cyc + 1 < last_ev + gap) tick();
  endtask

  task automatic fire(input logic [31:0] v, input bit store);
    int iv;
    iv = cyc + 1 - last_ev;
    last_ev = cyc + 1;
    in1 = v;
    if (store) q.push_back('{v, iv[15:0]});
    exp_cnt++;
    if (!first && iv != 5) exp_err = 1'b1;
    first = 1'b0;
    tick();
    chk("change_cnt", 64'(change_cnt), 64'(exp_cnt));
    chk("interval_err", 64'(interval_err), 64'(exp_err));
  endtask

  task automatic change(input logic [31:0] v,
                        input int gap,
                        input bit store);
    wait_gap(gap);
    fire(v, store);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    // 1: idle after reset
    in1 = 0;
    do_reset(3);
    repeat (20) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(change_cnt), 64'd0);
    chk("rst_ierr", 64'(interval_err), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_int", 64'(out_interval), 64'd0);

    // 2: regular cadence, consumer always ready
    do_reset(1);
    out_ready = 1'b1;
    change(1, 5, 1'b1);
    change(2, 5, 1'b1);
    change(1, 5, 1'b1);
    drain();
    chk("t2_ovf", 64'(overflow), 64'd0);

    // 3: consumer stalled, fifth change dropped
    out_ready = 1'b0;
    do_reset(1);
    change(10, 5, 1'b1);
    change(20, 5, 1'b1);
    change(30, 5, 1'b1);
    change(40, 5, 1'b1);
    chk("t3_ovf4", 64'(overflow), 64'd0);
    chk("t3_valid", 64'(out_valid), 64'd1);
    chk("t3_hold_d", 64'(out_data), 64'd10);
    change(50, 5, 1'b0);
    chk("t3_ovf5", 64'(overflow), 64'd1);
    change(60, 5, 1'b0);
    chk("t3_cnt6", 64'(change_cnt), 64'd6);
    drain();
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: short interval sets sticky error
    do_reset(1);
    out_ready = 1'b1;
    change(7, 5, 1'b1);
    change(8, 5, 1'b1);
    change(9, 3, 1'b1);
    chk("t4_ierr", 64'(interval_err), 64'd1);
    change(10, 5, 1'b1);
    repeat (4) tick();
    chk("t4_sticky", 64'(interval_err), 64'd1);
    drain();

    // 5: push and pop together on a full FIFO
    out_ready = 1'b0;
    do_reset(1);
    change(11, 5, 1'b1);
    change(12, 5, 1'b1);
    change(13, 5, 1'b1);
    change(14, 5, 1'b1);
    wait_gap(5);
    out_ready = 1'b1;
    fire(55, 1'b1);
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd1);
    drain();

    // 6: reset flushes queued records and flags
    out_ready = 1'b0;
    do_reset(1);
    change(21, 5, 1'b1);
    change(22, 3, 1'b1);
    chk("t6_pre_ierr", 64'(interval_err), 64'd1);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    do_reset(1);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ierr", 64'(interval_err), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_cnt", 64'(change_cnt), 64'd0);
    out_ready = 1'b1;
    change(23, 9, 1'b1);
    chk("t6_first_ierr", 64'(interval_err), 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
